// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the writeback entry type used by the
// register-file write-side controller and its secondary result FIFO.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    // One buffered secondary-unit result: destination register plus value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries. Pointers carry one extra
// wrap bit so full and empty are told apart by comparing the MSBs.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] din_rd,
    input  logic [XLEN-1:0]       din_data,
    input  logic                  pop,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [XLEN-1:0]       head_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    wb_entry_t       head;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_rd   = head.rd;
    assign head_data = head.data;

    // Advance the read/write pointers; they wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Store accepted entries at the write slot.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; empty pointers make stale contents unobservable.
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= '{rd: din_rd, data: din_data};
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the register file's single write port.
// Primary (ALU/load) results write with zero latency; secondary (mul/div)
// results are buffered and drain when the port is free. Also tracks
// registers awaiting secondary results and throttles the primary path
// when buffered results have waited too long.
module regfile_wb_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_valid,
    input  logic [4:0]  p_rd,
    input  logic [31:0] p_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_rd,
    input  logic [31:0] s_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3,
    output logic [31:0] pending,
    output logic        p_stall
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic                  push;
    logic                  pop;
    logic                  primary_win;

    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_next;
    logic [SW-1:0]         starve_cnt;
    logic [SW-1:0]         starve_next;

    // A full FIFO refuses new results even when it is draining this cycle.
    assign s_ready     = !fifo_full;
    // Results aimed at x0 are accepted but never stored.
    assign push        = s_valid && s_ready && (s_rd != '0);
    assign primary_win = p_valid && (p_rd != '0);
    assign pop         = rst_n && !primary_win && !fifo_empty;
    assign pending     = pending_q;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .din_rd    (s_rd),
        .din_data  (s_data),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Arbitrate the write port: primary first, then FIFO head, else idle.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        we3 = 1'b0;
        a3  = '0;
        wd3 = '0;
        if (rst_n && primary_win) begin
            we3 = 1'b1;
            a3  = p_rd;
            wd3 = p_data;
        end else if (rst_n && !fifo_empty) begin
            we3 = 1'b1;
            a3  = head_rd;
            wd3 = head_data;
        end
    end

    // Scoreboard next state: drain clears, issue sets afterwards so set wins.
    always_comb begin
        pending_next = pending_q;
        if (pop) begin
            pending_next[head_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Starve counter: count waiting cycles of a non-empty FIFO, saturating.
    always_comb begin
        starve_next = starve_cnt;
        if (fifo_empty || pop) begin
            starve_next = '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // Register scoreboard, starve counter and the one-cycle primary stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q  <= '0;
            starve_cnt <= '0;
            p_stall    <= 1'b0;
        end else begin
            pending_q  <= pending_next;
            starve_cnt <= starve_next;
            p_stall    <= (starve_next == STARVE_MAX);
        end
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-side controller for the 32x32 register file's single write port (WE3/A3/WD3). Arbitrates between the single-cycle primary writeback path (ALU/load) and a multi-cycle secondary unit (mul/div) that delivers results late through a valid/ready handshake. Secondary results are buffered in a small FIFO. The block keeps a pending-destination scoreboard for decode hazard stalls and enforces the x0 write discard.

Parameters:
DEPTH, 2, secondary result FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may go without draining before the primary path is stalled

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
p_valid  in  1  primary writeback valid; no ready; upstream holds p_valid=0 while p_stall=1
p_rd  in  5  primary destination register
p_data  in  32  primary result
s_valid  in  1  secondary result valid
s_ready  out  1  secondary result accepted this cycle when s_valid&s_ready
s_rd  in  5  secondary destination register
s_data  in  32  secondary result
issue_valid  in  1  decode dispatches an op to the secondary unit this cycle
issue_rd  in  5  destination of that op
we3  out  1  register file write enable
a3  out  5  register file write address
wd3  out  32  register file write data
pending  out  32  bit i=1: register i awaits a secondary result; bit 0 always 0
p_stall  out  1  registered request for upstream to withhold primary writes for one cycle

Behaviour:
- Reset (rst_n=0 at rising edge): FIFO empty, pending=0, starve counter=0, p_stall=0. While rst_n=0, we3 is forced to 0 combinationally.
- One register-file write per cycle. Write-port outputs are combinational from the current inputs and the FIFO head.
- Primary wins if p_valid=1 and p_rd!=0: we3=1, a3=p_rd, wd3=p_data. Zero latency.
- Otherwise, if the FIFO is non-empty: we3=1, a3=head.rd, wd3=head.data, and the head dequeues at the edge.
- Otherwise we3=0, a3=0, wd3=0.
- p_valid=1 with p_rd=0: no write. The secondary may drain in the same cycle.
- s_ready = !full. No enqueue/dequeue bypass: a newly accepted result is written no earlier than the next cycle.
- A full FIFO with a same-cycle dequeue still reports s_ready=0 that cycle.
- Accepted secondary result with s_rd=0 is consumed and discarded, not stored. Its pending bit is untouched.
- FIFO pointers are log2(DEPTH)+1 bits. Full/empty are derived from the MSB compare. Pointers wrap modulo 2*DEPTH.
- Pending scoreboard:
  - issue_valid with issue_rd!=0 sets bit issue_rd.
  - A secondary dequeue-write to rd clears bit rd.
  - Set and clear of the same bit in the same cycle: set wins.
  - issue_rd=0 is ignored.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Increments each cycle the FIFO is non-empty and no dequeue occurs.
  - Clears on dequeue or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- p_stall is registered. It is 1 in the cycle after the counter equals STARVE_LIMIT, and lasts exactly one cycle (the counter clears on the guaranteed dequeue).
- If p_valid=1 while p_stall=1, that is an upstream protocol violation. The primary still wins; no assertion in RTL, bench flags it.
- Reset mid-operation: FIFO contents are dropped, pending clears. Upstream reissues after reset.

Decomposition:
- Shared package cpu_pkg: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, and struct wb_entry_t {rd, data}.
- One natural sub-module, wb_fifo: a parameterized DEPTH synchronous FIFO of wb_entry_t with push/pop/full/empty. The arbiter, scoreboard and starve logic stay in the top.

Test Plan:
- Reset then idle -> we3=0, s_ready=1, pending=0, p_stall=0 for 5 cycles.
- p_valid=1,p_rd=5,p_data=0xDEADBEEF alone -> same cycle we3=1,a3=5,wd3=0xDEADBEEF. Repeat with p_rd=0 -> we3=0.
- issue_valid rd=7, later s_valid rd=7 data=0x12345678 with p_valid=0 -> pending[7]=1 from the next cycle. Write a3=7 occurs one cycle after acceptance, then pending[7]=0.
- Push 2 secondary results (rd=3, rd=4) while p_valid=1 every cycle -> s_ready=0 after 2 pushes. p_stall=1 in the cycle after 4 starved cycles. In that cycle (p_valid=0) rd=3 is written, then rd=4 drains later.
- Same cycle: issue_valid rd=9 and dequeue-write of rd=9 -> pending[9] remains 1.
- s_valid rd=0 data=0xFFFFFFFF -> accepted, never written, FIFO stays empty. Assert rst_n=0 with 2 entries queued -> FIFO empty and pending=0 after the edge.
